// File: rtl/inv_delay_meter_pkg.sv
// Shared types and defaults for the inverter delay meter.
// Kind encoding doubles as the expected output level (rise -> expect 1).
package inv_meter_pkg;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TIMEOUT = 200;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  typedef enum logic {
    FALL = 1'b0,
    RISE = 1'b1
  } kind_e;

  // An input that rose is followed by an output fall, and vice versa.
  function automatic kind_e kind_from_input(input logic in_level);
    return in_level ? FALL : RISE;
  endfunction

endpackage

// File: rtl/inv_delay_meter_edge_sample.sv
// Single-bit sampler: registered value, previous registered value and change flag.
// The first sample after reset also seeds the previous register, so no false edge appears.
module edge_sample
  import inv_meter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic prev,
  output logic chg
);

  logic cur_q, cur_d;
  logic prev_q, prev_d;
  logic primed_q, primed_d;

  always_comb begin
    cur_d    = d;
    prev_d   = primed_q ? cur_q : d;
    primed_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q    <= 1'b0;
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      cur_q    <= cur_d;
      prev_q   <= prev_d;
      primed_q <= primed_d;
    end
  end

  always_comb begin
    q    = cur_q;
    prev = prev_q;
    chg  = cur_q ^ prev_q;
  end

endmodule

// File: rtl/inv_delay_meter.sv
// Measures inverter propagation delay (in clk cycles) from each registered input edge
// to the matching registered output transition; rise and fall results are kept apart.
module inv_delay_meter
  import inv_meter_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl,
  input  logic             in_sig,
  input  logic             out_sig,
  output logic [CNT_W-1:0] rise_dly,
  output logic [CNT_W-1:0] fall_dly,
  output logic             meas_valid,
  output logic             meas_is_rise,
  output logic             timeout,
  output logic             overrun,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic in_q, in_prev_unused, in_edge;
  logic out_q, out_prev_unused, out_chg_unused;
  logic ctrl_q, ctrl_prev_unused, ctrl_chg_unused;
  logic out_gated;

  // A disabled inverter drives 0, whatever its output pin shows.
  assign out_gated = out_sig & ctrl;

  edge_sample u_in_smp (
    .clk  (clk),
    .rst  (rst),
    .d    (in_sig),
    .q    (in_q),
    .prev (in_prev_unused),
    .chg  (in_edge)
  );

  edge_sample u_out_smp (
    .clk  (clk),
    .rst  (rst),
    .d    (out_gated),
    .q    (out_q),
    .prev (out_prev_unused),
    .chg  (out_chg_unused)
  );

  edge_sample u_ctrl_smp (
    .clk  (clk),
    .rst  (rst),
    .d    (ctrl),
    .q    (ctrl_q),
    .prev (ctrl_prev_unused),
    .chg  (ctrl_chg_unused)
  );

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rise_dly_q, rise_dly_d;
  logic [CNT_W-1:0] fall_dly_q, fall_dly_d;
  logic             is_rise_q, is_rise_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;

  kind_e            kind_new, cap_kind;
  logic             exp_new, exp_cur, cap_en;
  logic [CNT_W-1:0] cap_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      kind_q     <= FALL;
      cnt_q      <= '0;
      rise_dly_q <= '0;
      fall_dly_q <= '0;
      is_rise_q  <= 1'b0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      cnt_q      <= cnt_d;
      rise_dly_q <= rise_dly_d;
      fall_dly_q <= fall_dly_d;
      is_rise_q  <= is_rise_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    cnt_d      = cnt_q;
    rise_dly_d = rise_dly_q;
    fall_dly_d = fall_dly_q;
    is_rise_d  = is_rise_q;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;
    overrun_d  = 1'b0;
    cap_en     = 1'b0;
    cap_kind   = kind_q;
    cap_val    = '0;
    kind_new   = kind_from_input(in_q);
    exp_new    = (kind_new == RISE);
    exp_cur    = (kind_q == RISE);

    case (state_q)
      IDLE: begin
        if (in_edge && ctrl_q) begin
          if (out_q == exp_new) begin
            cap_en   = 1'b1;
            cap_kind = kind_new;
          end else begin
            state_d = MEASURE;
            kind_d  = kind_new;
            cnt_d   = CNT_ONE;
          end
        end
      end
      MEASURE: begin
        if (!ctrl_q) begin
          state_d = IDLE;
        end else if (out_q == exp_cur) begin
          cap_en   = 1'b1;
          cap_kind = kind_q;
          cap_val  = cnt_q;
          // A coinciding input edge opens the next measurement right away.
          if (in_edge) begin
            kind_d = kind_new;
            cnt_d  = CNT_ONE;
          end else begin
            state_d = IDLE;
          end
        end else if (in_edge) begin
          overrun_d = 1'b1;
          kind_d    = kind_new;
          cnt_d     = CNT_ONE;
        end else if (cnt_q == TIMEOUT_CNT) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cap_en) begin
      valid_d   = 1'b1;
      is_rise_d = (cap_kind == RISE);
      if (cap_kind == RISE) rise_dly_d = cap_val;
      else                  fall_dly_d = cap_val;
    end
  end

  always_comb begin
    busy         = (state_q == MEASURE);
    rise_dly     = rise_dly_q;
    fall_dly     = fall_dly_q;
    meas_valid   = valid_q;
    meas_is_rise = is_rise_q;
    timeout      = timeout_q;
    overrun      = overrun_q;
  end

endmodule

// File: tb/tb_inv_delay_meter.sv
// Directed bench for inv_delay_meter: transport-delay inverter model drives the pins,
// an event-level measurement model predicts every output each cycle.
module tb_inv_delay_meter;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 200;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ctrl = 1'b1;
  logic             in_sig = 1'b0;
  logic             out_sig = 1'b1;
  logic [CNT_W-1:0] rise_dly, fall_dly;
  logic             meas_valid, meas_is_rise, timeout, overrun, busy;

  inv_delay_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl         (ctrl),
    .in_sig       (in_sig),
    .out_sig      (out_sig),
    .rise_dly     (rise_dly),
    .fall_dly     (fall_dly),
    .meas_valid   (meas_valid),
    .meas_is_rise (meas_is_rise),
    .timeout      (timeout),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transport-delay inverter model (pin level) ----------------
  typedef struct {int due; logic v;} ev_t;
  ev_t  evq[$];
  ev_t  keep[$];
  int   tcyc = 0;
  int   dly_fall = 2;
  int   dly_rise = 4;
  logic out_lvl = 1'b1;
  logic hold_out = 1'b0;
  logic hold_val = 1'b0;

  task automatic set_in(input logic v);
    int d;
    in_sig = v;
    d = v ? dly_fall : dly_rise;
    if (d == 0) begin
      out_lvl = ~v;
      out_sig = hold_out ? hold_val : out_lvl;
    end else begin
      evq.push_back('{due: tcyc + d, v: ~v});
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tcyc++;
      keep = {};
      for (int j = 0; j < evq.size(); j++) begin
        if (evq[j].due == tcyc) out_lvl = evq[j].v;
        else if (evq[j].due > tcyc) keep.push_back(evq[j]);
      end
      evq = keep;
      out_sig = hold_out ? hold_val : out_lvl;
    end
  endtask

  // ---------------- measurement model (event level) ----------------
  // Tracks an open measurement by its start cycle; delay = capture cycle - start cycle.
  int   mcyc = 0, start_cyc = 0, nsmp = 0;
  logic s_in = 0, s_prev = 0, s_out = 0, s_ctrl = 0;
  logic pending = 0, want = 0, edge_seen, new_exp;
  int   m_rise = 0, m_fall = 0;
  logic m_valid = 0, m_is_rise = 0, m_to = 0, m_ov = 0;

  task automatic record(input logic lvl, input int d);
    int v;
    v = (d > 255) ? 255 : d;
    if (lvl) begin m_rise = v; m_is_rise = 1'b1; end
    else     begin m_fall = v; m_is_rise = 1'b0; end
    m_valid = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      pending = 0; nsmp = 0; s_in = 0; s_prev = 0; s_out = 0; s_ctrl = 0;
      m_rise = 0; m_fall = 0; m_valid = 0; m_is_rise = 0; m_to = 0; m_ov = 0;
      mcyc = 0; start_cyc = 0; want = 0;
    end else begin
      mcyc++;
      edge_seen = (s_in != s_prev);
      new_exp = ~s_in;
      m_valid = 0; m_to = 0; m_ov = 0;
      if (pending) begin
        if (!s_ctrl) pending = 0;
        else if (s_out == want) begin
          record(want, mcyc - start_cyc);
          if (edge_seen) begin want = new_exp; start_cyc = mcyc; end
          else pending = 0;
        end else if (edge_seen) begin
          m_ov = 1; want = new_exp; start_cyc = mcyc;
        end else if (mcyc - start_cyc == TIMEOUT) begin
          m_to = 1; pending = 0;
        end
      end else if (edge_seen && s_ctrl) begin
        want = new_exp;
        if (s_out == want) record(want, 0);
        else begin pending = 1; start_cyc = mcyc; end
      end
      s_prev = (nsmp == 0) ? in_sig : s_in;
      s_in   = in_sig;
      s_out  = out_sig & ctrl;
      s_ctrl = ctrl;
      nsmp   = 1;
    end
  end

  // ---------------- per-cycle compare and event counters ----------------
  int   mon_cyc = 0, valid_cnt = 0, to_cnt = 0, ov_cnt = 0, busy_rises = 0;
  int   busy_rise_cyc = 0, to_cyc = 0;
  logic busy_prev = 0;

  initial forever begin
    @(posedge clk);
    #2;
    mon_cyc++;
    chk("busy", int'(busy), int'(pending));
    chk("rise_dly", int'(rise_dly), m_rise);
    chk("fall_dly", int'(fall_dly), m_fall);
    chk("meas_valid", int'(meas_valid), int'(m_valid));
    chk("meas_is_rise", int'(meas_is_rise), int'(m_is_rise));
    chk("timeout", int'(timeout), int'(m_to));
    chk("overrun", int'(overrun), int'(m_ov));
    if (meas_valid) valid_cnt++;
    if (timeout) begin to_cnt++; to_cyc = mon_cyc; end
    if (overrun) ov_cnt++;
    if (busy && !busy_prev) begin busy_rises++; busy_rise_cyc = mon_cyc; end
    busy_prev = busy;
  end

  // ---------------- directed tests ----------------
  int v0, t0, o0, b0;

  initial begin
    #1 rst = 1'b1;
    #20;
    chk("rst_busy", int'(busy), 0);
    chk("rst_rise", int'(rise_dly), 0);
    chk("rst_fall", int'(fall_dly), 0);
    chk("rst_valid", int'(meas_valid), 0);
    #1 rst = 1'b0;
    tick(3);

    // 1: regular toggling, fall 2 / rise 4
    dly_fall = 2; dly_rise = 4;
    v0 = valid_cnt; t0 = to_cnt;
    for (int i = 0; i < 6; i++) begin
      set_in(~in_sig);
      tick(10);
      chk("t1_is_rise", int'(meas_is_rise), in_sig ? 0 : 1);
      if (in_sig) chk("t1_fall", int'(fall_dly), 2);
      else        chk("t1_rise", int'(rise_dly), 4);
    end
    chk("t1_valids", valid_cnt - v0, 6);
    chk("t1_timeouts", to_cnt - t0, 0);
    $display("test1 toggling: rise_dly=%0d fall_dly=%0d", rise_dly, fall_dly);

    // 2: output stuck high -> timeout
    hold_out = 1'b1; hold_val = 1'b1;
    v0 = valid_cnt; t0 = to_cnt;
    set_in(1'b1);
    tick(215);
    chk("t2_timeouts", to_cnt - t0, 1);
    chk("t2_distance", to_cyc - busy_rise_cyc, 200);
    chk("t2_fall_kept", int'(fall_dly), 2);
    chk("t2_valids", valid_cnt - v0, 0);
    hold_out = 1'b0;
    tick(5);
    set_in(1'b0);
    tick(10);
    $display("test2 timeout: distance=%0d", to_cyc - busy_rise_cyc);

    // 3: ctrl toggles every 20 cycles, one cycle behind the input edges
    v0 = valid_cnt; t0 = to_cnt; b0 = busy_rises;
    for (int i = 0; i < 8; i++) begin
      set_in(~in_sig);
      tick(1);
      if (i % 2 == 0) ctrl = ~ctrl;
      tick(9);
    end
    chk("t3_valids", valid_cnt - v0, 2);
    chk("t3_timeouts", to_cnt - t0, 0);
    chk("t3_busy_starts", busy_rises - b0, 4);
    $display("test3 ctrl gating: valids=%0d starts=%0d", valid_cnt - v0, busy_rises - b0);

    // 4: double input edge 3 cycles apart, fall 4 / rise 6
    dly_fall = 4; dly_rise = 6;
    v0 = valid_cnt; o0 = ov_cnt;
    set_in(1'b1);
    tick(3);
    set_in(1'b0);
    tick(15);
    chk("t4_overruns", ov_cnt - o0, 1);
    chk("t4_valids", valid_cnt - v0, 1);
    chk("t4_is_rise", int'(meas_is_rise), 1);
    chk("t4_rise", int'(rise_dly), 6);
    chk("t4_fall_kept", int'(fall_dly), 2);
    $display("test4 overrun: rise_dly=%0d", rise_dly);

    // 5: reset in the middle of a measurement
    dly_fall = 8; dly_rise = 8;
    set_in(1'b1);
    tick(4);
    chk("t5_busy_before", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_rise", int'(rise_dly), 0);
    chk("t5_rst_fall", int'(fall_dly), 0);
    chk("t5_rst_valid", int'(meas_valid), 0);
    #14 rst = 1'b0;
    v0 = valid_cnt; t0 = to_cnt;
    tick(20);
    chk("t5_no_valid", valid_cnt - v0, 0);
    chk("t5_no_timeout", to_cnt - t0, 0);
    set_in(1'b0);
    tick(12);
    chk("t5_rise", int'(rise_dly), 8);
    chk("t5_valid_after", valid_cnt - v0, 1);
    $display("test5 reset: rise_dly=%0d", rise_dly);

    // 6: zero-delay inverter
    dly_fall = 0; dly_rise = 0;
    v0 = valid_cnt; b0 = busy_rises;
    set_in(1'b1);
    tick(5);
    chk("t6_fall", int'(fall_dly), 0);
    chk("t6_is_rise_f", int'(meas_is_rise), 0);
    set_in(1'b0);
    tick(5);
    chk("t6_rise", int'(rise_dly), 0);
    chk("t6_is_rise_r", int'(meas_is_rise), 1);
    chk("t6_valids", valid_cnt - v0, 2);
    chk("t6_no_busy", busy_rises - b0, 0);
    $display("test6 zero delay: valids=%0d", valid_cnt - v0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
